// File: rtl/db_pkg.sv
// Shared definitions for the multi-channel switch debouncer.
// Holds the per-channel FSM state encoding and the default settle time.
package db_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_t;

    // 10 ms at a 50 MHz system clock
    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/db_channel.sv
// Single debounce channel: a four-state FSM with a settle counter.
// The output level only changes after the input has been steady for
// DB_CYCLES consecutive clocks; rise/fall pulse on the clock db changes.
module db_channel
    import db_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    db_state_t     state;
    db_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          rise_n;
    logic          fall_n;

    // State, counter and registered outputs; db is decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            db    <= (state_n == ONE) || (state_n == WAIT0);
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    // Next-state logic; the counter runs only while waiting and restarts on every wait entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            ZERO: begin
                if (x) begin
                    state_n = WAIT1;
                    cnt_n   = '0;
                end
            end
            WAIT1: begin
                if (!x) begin
                    state_n = ZERO;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = ONE;
                    cnt_n   = '0;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ONE: begin
                if (!x) begin
                    state_n = WAIT0;
                    cnt_n   = '0;
                end
            end
            WAIT0: begin
                if (x) begin
                    state_n = ONE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = ZERO;
                    cnt_n   = '0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ZERO;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent switch debouncers with per-channel input inversion.
// Optional feature: define MULTI_DEBOUNCE_SYNC_EN to add a 2-flop
// synchroniser on every sw bit (adds 2 clocks of latency). Without it
// the sw inputs must already be synchronous to clk.
module multi_debounce
    import db_pkg::*;
#(
    parameter int              N_CH      = 4,
    parameter int              DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter logic [N_CH-1:0] INV_MASK  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    logic [N_CH-1:0] sw_s;
    logic [N_CH-1:0] x;

`ifdef MULTI_DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] sw_meta;

    // Two-stage synchroniser for the asynchronous switch levels
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end
`else
    assign sw_s = sw;
`endif

    // Active-low switches are flipped here so every FSM sees active-high
    assign x = sw_s ^ INV_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .x     (x[i]),
            .db    (db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce (N_CH=4, DB_CYCLES=8).
// Two instances: one without inversion, one with INV_MASK=4'b1000.
// Follows MULTI_DEBOUNCE_SYNC_EN to pick the expected latency.
module tb_multi_debounce;

    localparam int N   = 4;
    localparam int D   = 8;
`ifdef MULTI_DEBOUNCE_SYNC_EN
    localparam int SYN = 2;
`else
    localparam int SYN = 0;
`endif
    localparam int LAT = D + SYN;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] db;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [3:0] db0;
        logic [3:0] db1;
    } snap_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] sw0;
    logic [N-1:0] sw1;
    logic [N-1:0] db0, rise0, fall0;
    logic [N-1:0] db1, rise1, fall1;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  done = 1'b0;
    ev_t   q0[$];
    ev_t   q1[$];
    snap_t snaps[$];

    multi_debounce #(.N_CH(N), .DB_CYCLES(D), .INV_MASK(4'b0000)) dut0 (
        .clk (clk), .reset (reset), .sw (sw0),
        .db (db0), .rise (rise0), .fall (fall0)
    );

    multi_debounce #(.N_CH(N), .DB_CYCLES(D), .INV_MASK(4'b1000)) dut1 (
        .clk (clk), .reset (reset), .sw (sw1),
        .db (db1), .rise (rise1), .fall (fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] s0, input logic [3:0] s1);
        sw0 = s0;
        sw1 = s1;
    endtask

    task automatic expectEvent(input int which, input int c, input logic [3:0] r,
                               input logic [3:0] f, input logic [3:0] d);
        ev_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.db   = d;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic checkOutput(input int c, input logic [3:0] d0, input logic [3:0] d1);
        snap_t s;
        s.cyc = c;
        s.db0 = d0;
        s.db1 = d1;
        snaps.push_back(s);
    endtask

    // Stimulus: directed vectors, expected responses pushed as they are issued
    initial begin
        int e;
        logic [5:0] bounce;
        reset = 1'b1;
        applyStimulus(4'hF, 4'h0);
        checkOutput(2, 4'h0, 4'h0);
        tick(3);

        // release with all switches high; dut1 ch3 is already active via inversion
        e = cyc;
        reset = 1'b0;
        expectEvent(0, e + 1 + LAT, 4'hF, 4'h0, 4'hF);
        expectEvent(1, e + 1 + D,   4'h8, 4'h0, 4'h8);
        tick(LAT + 4);

        // all channels released together
        e = cyc;
        applyStimulus(4'h0, 4'h0);
        expectEvent(0, e + 1 + LAT, 4'h0, 4'hF, 4'h0);
        tick(LAT + 4);
        checkOutput(cyc, 4'h0, 4'h8);

        // single channel press
        e = cyc;
        applyStimulus(4'h1, 4'h0);
        expectEvent(0, e + 1 + LAT, 4'h1, 4'h0, 4'h1);
        tick(LAT + 4);

        // 7-clock glitch on ch1 must be swallowed
        applyStimulus(4'h3, 4'h0);
        tick(7);
        applyStimulus(4'h1, 4'h0);
        tick(LAT + 4);
        checkOutput(cyc, 4'h1, 4'h8);

        // bounce on ch2, then solid high
        bounce = 6'b001101;
        for (int i = 0; i < 5; i++) begin
            applyStimulus({1'b0, bounce[i], 2'b01}, 4'h0);
            tick(1);
        end
        e = cyc;
        applyStimulus(4'h5, 4'h0);
        expectEvent(0, e + 1 + LAT, 4'h4, 4'h0, 4'h5);
        tick(LAT + 4);
        checkOutput(cyc, 4'h5, 4'h8);

        // simultaneous releases on both instances, inverted ch3 goes high on sw
        e = cyc;
        applyStimulus(4'h0, 4'h8);
        expectEvent(0, e + 1 + LAT, 4'h0, 4'h5, 4'h0);
        expectEvent(1, e + 1 + LAT, 4'h0, 4'h8, 4'h0);
        tick(LAT + 4);

        // reset in the middle of a count aborts it; a full window follows release
        applyStimulus(4'h1, 4'h8);
        tick(6);
        reset = 1'b1;
        checkOutput(cyc + 1, 4'h0, 4'h0);
        tick(2);
        e = cyc;
        reset = 1'b0;
        expectEvent(0, e + 1 + LAT, 4'h1, 4'h0, 4'h1);
        tick(LAT + 4);
        checkOutput(cyc, 4'h1, 4'h0);
        tick(2);
        done = 1'b1;
    end

    // Monitor: pops expectations whenever an instance reports an edge, plus level snapshots
    always @(negedge clk) begin
        ev_t   ev;
        snap_t s;
        if (rise0 !== 4'h0 || fall0 !== 4'h0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut0_event: got rise=%h fall=%h db=%h at cycle %0d, required no event",
                         rise0, fall0, db0, cyc);
            end else begin
                ev = q0.pop_front();
                if (ev.cyc != cyc || ev.rise !== rise0 || ev.fall !== fall0 || ev.db !== db0) begin
                    errors++;
                    $display("[TB] FAIL dut0_event: got cyc=%0d rise=%h fall=%h db=%h, required cyc=%0d rise=%h fall=%h db=%h",
                             cyc, rise0, fall0, db0, ev.cyc, ev.rise, ev.fall, ev.db);
                end
            end
        end
        if (rise1 !== 4'h0 || fall1 !== 4'h0) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut1_event: got rise=%h fall=%h db=%h at cycle %0d, required no event",
                         rise1, fall1, db1, cyc);
            end else begin
                ev = q1.pop_front();
                if (ev.cyc != cyc || ev.rise !== rise1 || ev.fall !== fall1 || ev.db !== db1) begin
                    errors++;
                    $display("[TB] FAIL dut1_event: got cyc=%0d rise=%h fall=%h db=%h, required cyc=%0d rise=%h fall=%h db=%h",
                             cyc, rise1, fall1, db1, ev.cyc, ev.rise, ev.fall, ev.db);
                end
            end
        end
        while (snaps.size() > 0 && snaps[0].cyc <= cyc) begin
            s = snaps.pop_front();
            checks++;
            if (s.cyc != cyc || db0 !== s.db0 || db1 !== s.db1 ||
                rise0 !== 4'h0 || fall0 !== 4'h0 || rise1 !== 4'h0 || fall1 !== 4'h0) begin
                errors++;
                $display("[TB] FAIL level_snapshot: cyc=%0d db0=%h db1=%h r0=%h f0=%h r1=%h f1=%h, required cyc=%0d db0=%h db1=%h no pulses",
                         cyc, db0, db1, rise0, fall0, rise1, fall1, s.cyc, s.db0, s.db1);
            end
        end
        if (done) begin
            checks++;
            if (q0.size() != 0) begin
                errors++;
                $display("[TB] FAIL dut0_missing: %0d expected events never seen, required 0", q0.size());
            end
            checks++;
            if (q1.size() != 0) begin
                errors++;
                $display("[TB] FAIL dut1_missing: %0d expected events never seen, required 0", q1.size());
            end
            checks++;
            if (snaps.size() != 0) begin
                errors++;
                $display("[TB] FAIL snap_missing: %0d snapshots not taken, required 0", snaps.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: stimulus did not complete, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 4: number of independent debounce channels, 1..32.
REQ-002 Parameter DB_CYCLES, default 500000: stable-level clock count required before the output changes (10 ms at 50 MHz), minimum 2.
REQ-003 Parameter INV_MASK, N_CH bits, default all 0: a bit set inverts that channel's raw input before debouncing (active-low switches).
REQ-004 clk  input  1  system clock; all logic is on the rising edge; one clock domain only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw  input  N_CH  raw asynchronous switch/button levels, one bit per channel.
REQ-007 db  output  N_CH  debounced level per channel, registered.
REQ-008 rise  output  N_CH  one-clock pulse per channel when db goes 0->1, registered.
REQ-009 fall  output  N_CH  one-clock pulse per channel when db goes 1->0, registered.

Function
REQ-010 Each channel SHALL run an independent 4-state FSM (ZERO, WAIT1, ONE, WAIT0) with its own counter of width $clog2(DB_CYCLES).
REQ-011 The FSM input x SHALL be sw[i] XOR INV_MASK[i] after the optional synchroniser (REQ-024).
REQ-012 ZERO: x=1 -> WAIT1 with counter cleared; x=0 -> stay.
REQ-013 WAIT1: x=0 -> ZERO with no output change; x=1 and counter==DB_CYCLES-1 -> ONE; otherwise counter+1.
REQ-014 ONE: x=0 -> WAIT0 with counter cleared; x=1 -> stay.
REQ-015 WAIT0: x=1 -> ONE with no output change; x=0 and counter==DB_CYCLES-1 -> ZERO; otherwise counter+1.
REQ-016 db[i] SHALL be 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-017 rise[i] SHALL be 1 for exactly the first cycle in which db[i] is 1 after the WAIT1->ONE transition; fall[i] likewise for WAIT0->ZERO; never both set together.
REQ-018 Latency: with x held at the new level from edge k, db SHALL change at edge k+DB_CYCLES, i.e. DB_CYCLES+1 clocks after the raw change when DB_SYNC_EN is off.
REQ-019 Any excursion of x shorter than DB_CYCLES clocks SHALL produce no change on db, rise or fall, and SHALL restart the count on the next attempt.
REQ-020 The counter SHALL never wrap; it is held only in WAIT states and is cleared on each WAIT entry.
REQ-021 Channels SHALL not interact; simultaneous transitions on any subset of channels SHALL each be reported in the same cycle.

Reset
REQ-022 While reset=1, every channel SHALL enter ZERO with counter 0, and db, rise and fall SHALL be 0 on the next edge, regardless of sw or INV_MASK.
REQ-023 Reset asserted mid-count SHALL abort the count; after release, a channel whose x=1 SHALL need a full DB_CYCLES window before db rises (rise is pulsed).

Configuration
REQ-024 With macro MULTI_DEBOUNCE_SYNC_EN defined, each sw bit SHALL pass through a 2-flop synchroniser (reset to 0) before the FSM, adding 2 clocks to REQ-018 latency; without it, sw feeds the FSM directly and the inputs are required to be synchronous.

Structure
REQ-025 A shared package db_pkg SHALL hold the FSM state enum (ZERO, WAIT1, ONE, WAIT0, 2-bit encoding) and the default DB_CYCLES constant.
REQ-026 The per-channel FSM plus counter SHALL be sub-module db_channel; multi_debounce instantiates N_CH copies via generate, plus the optional synchroniser.

Verification (N_CH=4, DB_CYCLES=8, macro off unless stated)
REQ-027 Reset with sw=4'hF -> db=0, rise=0, fall=0; after release, db=4'hF exactly 9 clocks after release, with rise=4'hF for one cycle.
REQ-028 sw[0] 0->1 held -> db[0]=1 at edge k+8, rise[0] pulses one cycle; other channels stay 0.
REQ-029 sw[1] glitch high for 7 clocks, then low -> db[1], rise[1] and fall[1] stay 0 throughout.
REQ-030 Bounce pattern on sw[2] (1,0,1,1,0, then solid 1) -> a single rise[2] pulse, 8 clocks after the final 0->1.
REQ-031 INV_MASK=4'b1000 with sw[3]=0 -> db[3]=1 after 8 clocks; then sw[3]=1 held -> fall[3] pulse and db[3]=0.
REQ-032 Macro defined: repeat REQ-028 -> db[0] rises at edge k+10; reset asserted in WAIT1 at count 5 -> no rise, and a full recount is required after release.
